register_bank: RTL
==================

# register_bank

Architectural register storage for the multicycle MIPS datapath: 32 registers of WORD_LENGTH bits with one synchronous write port. Each register is driven continuously onto its own output, Reg_0 to Reg_31. These outputs feed the two 32-input read multiplexers that select the rs and rt operands. Register $zero is hardwired to zero. $gp and $sp are loaded with fixed start addresses on reset.

## Interface
- WORD_LENGTH, 32, width of each register and of the write data.
- GP_RESET, 32'h1000_8000, reset value of register 28 ($gp).
- SP_RESET, 32'h7FFF_EFFC, reset value of register 29 ($sp).
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
- Reg_Write  input  1  write enable, sampled on the rising edge of clk.
- Write_Register  input  5  destination register index.
- Write_Data  input  WORD_LENGTH  value to store.
- Reg_0 … Reg_31  output  WORD_LENGTH each  current contents of registers 0–31, driven straight from the flops.

## Operation
- Storage:
  - Registers 1–31 are flops.
  - Reg_0 is a constant 0. It has no flop, and writes to index 0 are discarded.
- Write decode:
  - A 5-to-32 one-hot decode of Write_Register, gated by Reg_Write, gives one enable per register.
  - At most one register is written per cycle.
- Edge priority:
  - reset=1: every register takes its reset value, whatever Reg_Write is.
  - Otherwise, Reg_Write=1 and Write_Register=n with n≠0: register n ← Write_Data.
  - Every other register holds its value.
- Reset values:
  - Reg_28 = GP_RESET.
  - Reg_29 = SP_RESET.
  - All other registers = 0.
- Write index out of range: not possible, because all 32 codes of the 5-bit index are decoded.
- Unknown Write_Register while Reg_Write=0: no register changes.
- Arithmetic: none. Write_Data is stored bit-exact, with no sign extension or truncation.
- No read port inside the block. Operand selection belongs to the downstream multiplexers.

## Timing
- Write latency:
  - A write sampled on edge k is visible on Reg_n immediately after edge k.
  - It is therefore available to the downstream multiplexers in cycle k+1.
- Read during write:
  - In the cycle where Reg_Write=1, Reg_n still shows the old value.
  - No internal bypass is provided. The multicycle control never reads and writes the same register in one state.
- Reset takes effect on the first rising edge with reset=1.
  - Outputs hold their reset values on every edge while reset stays high.
  - The first write can land on the first edge after reset falls.
- Reset asserted in the same cycle as a write: reset wins, and the write is lost.
- Back-to-back writes to the same register on consecutive edges: each edge stores its own Write_Data, and the last one wins.
- Back-to-back writes to different registers: both are kept, and neither disturbs the other.
- Outputs are glitch-free flop outputs. Reg_0 is static.

## Test plan
- Reset check:
  - Stimulus: hold reset=1 for 2 cycles with Reg_Write=1, Write_Register=5, Write_Data=32'hDEAD_BEEF.
  - Required: Reg_28=32'h1000_8000, Reg_29=32'h7FFF_EFFC, Reg_5=0, and every other output 0.
- Write-all sweep:
  - Stimulus: after reset, write Write_Data=32'hA5A5_0000+n to each n=0..31, one per cycle, then idle.
  - Required: Reg_n=32'hA5A5_0000+n for n=1..31, and Reg_0=0.
- Write-enable gating:
  - Stimulus: Reg_Write=0, Write_Register=8, Write_Data=32'hFFFF_FFFF for 4 cycles.
  - Required: Reg_8 and all other registers unchanged.
- Write latency:
  - Stimulus: write 32'h0000_1234 to register 9 on edge k.
  - Required: Reg_9 is the old value before edge k and 32'h0000_1234 after it.
  - Required: Reg_8 and Reg_10 unchanged.
- Reset beats write, including mid-operation:
  - Stimulus: after loading Reg_29=32'h0000_0100, assert reset=1 with Reg_Write=1, Write_Register=29, Write_Data=32'h1111_1111 for one cycle.
  - Required: Reg_29=32'h7FFF_EFFC.
  - Next, with reset=0, write 32'h2222_2222 to register 29. Required: Reg_29=32'h2222_2222 one edge later.
- Consecutive writes to the same register:
  - Stimulus: write 32'h1 then 32'h2 to register 31 on consecutive edges.
  - Required: Reg_31=1 after the first edge and 2 after the second.
  - Required: Reg_30 unchanged.

Source files
------------

// File: rtl/register_bank.sv
// MIPS architectural register file: 31 flopped registers plus a hardwired $zero,
// one synchronous write port, every register exposed on its own output.
module register_bank #(
  parameter int                     WORD_LENGTH = 32,
  parameter logic [WORD_LENGTH-1:0] GP_RESET    = 32'h1000_8000,
  parameter logic [WORD_LENGTH-1:0] SP_RESET    = 32'h7FFF_EFFC
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Reg_Write,
  input  logic [4:0]             Write_Register,
  input  logic [WORD_LENGTH-1:0] Write_Data,
  output logic [WORD_LENGTH-1:0] Reg_0,
  output logic [WORD_LENGTH-1:0] Reg_1,
  output logic [WORD_LENGTH-1:0] Reg_2,
  output logic [WORD_LENGTH-1:0] Reg_3,
  output logic [WORD_LENGTH-1:0] Reg_4,
  output logic [WORD_LENGTH-1:0] Reg_5,
  output logic [WORD_LENGTH-1:0] Reg_6,
  output logic [WORD_LENGTH-1:0] Reg_7,
  output logic [WORD_LENGTH-1:0] Reg_8,
  output logic [WORD_LENGTH-1:0] Reg_9,
  output logic [WORD_LENGTH-1:0] Reg_10,
  output logic [WORD_LENGTH-1:0] Reg_11,
  output logic [WORD_LENGTH-1:0] Reg_12,
  output logic [WORD_LENGTH-1:0] Reg_13,
  output logic [WORD_LENGTH-1:0] Reg_14,
  output logic [WORD_LENGTH-1:0] Reg_15,
  output logic [WORD_LENGTH-1:0] Reg_16,
  output logic [WORD_LENGTH-1:0] Reg_17,
  output logic [WORD_LENGTH-1:0] Reg_18,
  output logic [WORD_LENGTH-1:0] Reg_19,
  output logic [WORD_LENGTH-1:0] Reg_20,
  output logic [WORD_LENGTH-1:0] Reg_21,
  output logic [WORD_LENGTH-1:0] Reg_22,
  output logic [WORD_LENGTH-1:0] Reg_23,
  output logic [WORD_LENGTH-1:0] Reg_24,
  output logic [WORD_LENGTH-1:0] Reg_25,
  output logic [WORD_LENGTH-1:0] Reg_26,
  output logic [WORD_LENGTH-1:0] Reg_27,
  output logic [WORD_LENGTH-1:0] Reg_28,
  output logic [WORD_LENGTH-1:0] Reg_29,
  output logic [WORD_LENGTH-1:0] Reg_30,
  output logic [WORD_LENGTH-1:0] Reg_31
);

  // Index 0 has no storage; decode and flops cover 1..31 only.
  logic [31:1]                  wr_en;
  logic [31:1][WORD_LENGTH-1:0] regs_d, regs_q;

  always_comb begin
    wr_en  = '0;
    regs_d = regs_q;
    for (int i = 1; i < 32; i++) begin
      wr_en[i] = Reg_Write && (Write_Register == 5'(i));
      if (wr_en[i]) regs_d[i] = Write_Data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < 32; i++)
        regs_q[i] <= (i == 28) ? GP_RESET : (i == 29) ? SP_RESET : '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign Reg_0  = '0;
  assign Reg_1  = regs_q[1];
  assign Reg_2  = regs_q[2];
  assign Reg_3  = regs_q[3];
  assign Reg_4  = regs_q[4];
  assign Reg_5  = regs_q[5];
  assign Reg_6  = regs_q[6];
  assign Reg_7  = regs_q[7];
  assign Reg_8  = regs_q[8];
  assign Reg_9  = regs_q[9];
  assign Reg_10 = regs_q[10];
  assign Reg_11 = regs_q[11];
  assign Reg_12 = regs_q[12];
  assign Reg_13 = regs_q[13];
  assign Reg_14 = regs_q[14];
  assign Reg_15 = regs_q[15];
  assign Reg_16 = regs_q[16];
  assign Reg_17 = regs_q[17];
  assign Reg_18 = regs_q[18];
  assign Reg_19 = regs_q[19];
  assign Reg_20 = regs_q[20];
  assign Reg_21 = regs_q[21];
  assign Reg_22 = regs_q[22];
  assign Reg_23 = regs_q[23];
  assign Reg_24 = regs_q[24];
  assign Reg_25 = regs_q[25];
  assign Reg_26 = regs_q[26];
  assign Reg_27 = regs_q[27];
  assign Reg_28 = regs_q[28];
  assign Reg_29 = regs_q[29];
  assign Reg_30 = regs_q[30];
  assign Reg_31 = regs_q[31];

endmodule
